// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, the reset fetch address and
// the {pc, inst} entry carried through the prefetch queue.
package fetch_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_BITS = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a one-cycle clear; read data is the
// current head, so the consumer sees it combinationally.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst_n && !clear) begin
         assert (!(push && !pop && count == FULL));
         assert (!(pop && count == '0));
      end
   end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction-fetch stage: sequential fetch over req/gnt/rvalid memory, a
// prefetch queue toward decode, and redirect flushing of queued and in-flight words.
module inst_prefetch
   import fetch_pkg::*;
#(
   parameter int              XLEN      = XLEN_DEFAULT,
   parameter int              DEPTH     = 4,
   parameter int              MAX_OUTST = 2,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            jmp,
   input  logic [XLEN-1:0] pc_jmp_i,
   input  logic            branch,
   input  logic [XLEN-1:0] pc_branch_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            inst_valid_o,
   input  logic            inst_ready_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_o
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTST);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] STEP  = XLEN'(4);

   logic [XLEN-1:0]   fpc;
   logic [XLEN-1:0]   rpc;
   logic [XLEN-1:0]   target;
   logic [CW-1:0]     outst;
   logic [CW-1:0]     drop;
   logic [CW-1:0]     count;
   logic [2*XLEN-1:0] head;
   logic              redirect;
   logic              issue;
   logic              push;
   logic              pop;

   // Credits count both in-flight words and queued words, so every granted
   // request is guaranteed a queue slot when its response arrives.
   always_comb begin
      redirect     = jmp | branch;
      target       = jmp ? pc_jmp_i : pc_branch_i;
      target[1:0]  = 2'b00;
      imem_req_o   = rst_n & ~redirect & (outst < MAX_W) &
                     (({1'b0, outst} + {1'b0, count}) < DEPTH_W);
      imem_addr_o  = fpc;
      issue        = imem_req_o & imem_gnt_i;
      push         = imem_rvalid_i & ~redirect & (drop == '0);
      inst_valid_o = (count != '0) & ~redirect;
      pop          = inst_valid_o & inst_ready_i;
      inst_o       = (count != '0) ? head[XLEN-1:0] : '0;
      pc_o         = (count != '0) ? head[2*XLEN-1:XLEN] : '0;
   end

   // On redirect every request still outstanding after this edge belongs to
   // the old path, so all of them are marked for discard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc   <= RESET_PC;
         rpc   <= RESET_PC;
         outst <= '0;
         drop  <= '0;
      end else begin
         outst <= outst + CW'(issue) - CW'(imem_rvalid_i);
         if (redirect) begin
            fpc  <= target;
            rpc  <= target;
            drop <= outst - CW'(imem_rvalid_i);
         end else begin
            if (issue) fpc <= fpc + STEP;
            if (push)  rpc <= rpc + STEP;
            if (imem_rvalid_i && drop != '0) drop <= drop - CW'(1);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (redirect),
      .push  (push),
      .wdata ({rpc, imem_rdata_i}),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (rst_n) assert (!(imem_rvalid_i && outst == '0));
   end

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: vector table, directed corner cases
// and a random phase checked against an epoch-tagged queue model.
module tb_inst_prefetch;

   localparam int          XLEN      = 32;
   localparam int          DEPTH     = 4;
   localparam int          MAX_OUTST = 2;
   localparam logic [31:0] RESET_PC  = 32'h0;

   logic        clk;
   logic        rst_n;
   logic        jmp, branch;
   logic [31:0] pc_jmp, pc_branch;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, pc;

   inst_prefetch #(
      .XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .jmp(jmp), .pc_jmp_i(pc_jmp), .branch(branch), .pc_branch_i(pc_branch),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
      .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
      .inst_o(inst), .pc_o(pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   typedef struct {
      logic        gnt;
      logic        ready;
      int          lat;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   mreq_t       mem_q[$];
   entry_t      q[$];
   int          outst, epoch, cyc;
   logic [31:0] fpc;
   int          vectors, miscompares;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc, s_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic modelReset();
      q.delete();
      mem_q.delete();
      outst = 0;
      fpc   = RESET_PC;
      epoch++;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      jmp = 0; branch = 0; pc_jmp = '0; pc_branch = '0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; inst_ready = 0;
      #1;
      check("reset_req",   {31'b0, imem_req},   32'h0);
      check("reset_valid", {31'b0, inst_valid}, 32'h0);
      check("reset_inst",  inst,                32'h0);
      check("reset_pc",    pc,                  32'h0);
      check("reset_addr",  imem_addr,           RESET_PC);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic checkOutput(input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_valid, input logic [31:0] exp_pc,
                              input logic [31:0] exp_inst);
      s_req   = imem_req;
      s_addr  = imem_addr;
      s_valid = inst_valid;
      s_pc    = pc;
      s_inst  = inst;
      check("imem_req",   {31'b0, s_req},   {31'b0, exp_req});
      check("imem_addr",  s_addr,           exp_addr);
      check("inst_valid", {31'b0, s_valid}, {31'b0, exp_valid});
      check("pc_o",       s_pc,             exp_pc);
      check("inst_o",     s_inst,           exp_inst);
   endtask

   // One cycle: drive inputs just after the falling edge, check against the
   // model, advance the model, then wait for the next falling edge.
   task automatic applyStimulus(input logic j, input logic [31:0] pj,
                                input logic b, input logic [31:0] pb,
                                input logic g, input logic r, input int lat);
      logic        resp, redir, exp_req, exp_valid;
      logic [31:0] tgt;
      mreq_t       head;
      entry_t      e;
      head = '{addr: 32'h0, epoch: 0, due: 0};
      jmp = j; pc_jmp = pj; branch = b; pc_branch = pb;
      imem_gnt = g; inst_ready = r;
      resp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      if (resp) head = mem_q[0];
      imem_rvalid = resp;
      imem_rdata  = resp ? mem_word(head.addr) : $urandom;
      redir     = j | b;
      tgt       = (j ? pj : pb) & 32'hFFFF_FFFC;
      exp_req   = !redir && (outst < MAX_OUTST) && (outst + q.size() < DEPTH);
      exp_valid = (q.size() != 0) && !redir;
      #1;
      if (q.size() != 0) checkOutput(exp_req, fpc, exp_valid, q[0].pc, q[0].inst);
      else               checkOutput(exp_req, fpc, exp_valid, 32'h0, 32'h0);
      if (redir) begin
         q.delete();
         epoch++;
         fpc = tgt;
      end else begin
         if (exp_valid && r) void'(q.pop_front());
         if (resp && head.epoch == epoch) begin
            e.pc = head.addr; e.inst = mem_word(head.addr);
            q.push_back(e);
         end
         if (exp_req && g) begin
            mem_q.push_back('{addr: fpc, epoch: epoch, due: cyc + lat});
            fpc = fpc + 32'd4;
            outst++;
         end
      end
      if (resp) begin
         void'(mem_q.pop_front());
         outst--;
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t tbl[6];
      bit   found;
      vectors = 0; miscompares = 0; cyc = 0; epoch = 0;

      // Streaming after reset: full grant, 1-cycle latency, decode always ready
      tbl[0] = '{1, 1, 1, 1, 32'h00, 0, 32'h0};
      tbl[1] = '{1, 1, 1, 1, 32'h04, 0, 32'h0};
      tbl[2] = '{1, 1, 1, 1, 32'h08, 1, 32'h0};
      tbl[3] = '{1, 1, 1, 1, 32'h0C, 1, 32'h4};
      tbl[4] = '{1, 1, 1, 1, 32'h10, 1, 32'h8};
      tbl[5] = '{1, 1, 1, 1, 32'h14, 1, 32'hC};

      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 0, 0, tbl[i].gnt, tbl[i].ready, tbl[i].lat);
         check("tbl_req",   {31'b0, s_req},   {31'b0, tbl[i].exp_req});
         check("tbl_addr",  s_addr,           tbl[i].exp_addr);
         check("tbl_valid", {31'b0, s_valid}, {31'b0, tbl[i].exp_valid});
         check("tbl_pc",    s_pc,             tbl[i].exp_pc);
         if (tbl[i].exp_valid) check("tbl_inst", s_inst, mem_word(tbl[i].exp_pc));
      end

      $display("[TB] decode stall fills queue");
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 0, 1);
      check("stall_req_off", {31'b0, s_req},   32'h0);
      check("stall_valid",   {31'b0, s_valid}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 1);
         check("drain_valid", {31'b0, s_valid}, 32'h1);
         check("drain_pc",    s_pc,             32'(i * 4));
      end

      $display("[TB] branch with two outstanding requests");
      doReset();
      applyStimulus(0, 0, 0, 0, 1, 1, 3);
      applyStimulus(0, 0, 0, 0, 1, 1, 3);
      applyStimulus(0, 0, 1, 32'h100, 1, 1, 3);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 1, 3);
         if (s_valid) begin
            found = 1;
            check("branch_first_pc",   s_pc,   32'h100);
            check("branch_first_inst", s_inst, mem_word(32'h100));
         end
      end
      if (!found) check("branch_first_valid_seen", 32'h0, 32'h1);

      $display("[TB] jump beats branch");
      doReset();
      repeat (2) applyStimulus(0, 0, 0, 0, 1, 1, 1);
      applyStimulus(1, 32'h200, 1, 32'h300, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      check("jmp_wins_req",  {31'b0, s_req}, 32'h1);
      check("jmp_wins_addr", s_addr,         32'h200);

      $display("[TB] target alignment and address wrap");
      doReset();
      repeat (2) applyStimulus(0, 0, 0, 0, 1, 1, 1);
      applyStimulus(1, 32'h0000_0103, 0, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      check("align_addr", s_addr, 32'h100);
      applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      check("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      check("wrap_req",  {31'b0, s_req}, 32'h1);
      check("wrap_addr", s_addr,         32'h0);

      $display("[TB] reset pulse mid-burst");
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1, 0, 3);
      #2;
      doReset();
      applyStimulus(0, 0, 0, 0, 1, 1, 1);
      check("restart_req",  {31'b0, s_req}, 32'h1);
      check("restart_addr", s_addr,         RESET_PC);

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(($urandom % 25) == 0, $urandom,
                       ($urandom % 20) == 0, $urandom,
                       ($urandom % 4) != 0, ($urandom % 3) != 0,
                       int'($urandom_range(1, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
